dice_lights_engine: RTL

//  Parametrised dice and traffic-light generator behind a single output mux.

---
 rtl/dice_lights_engine.sv | 97 +++++++++
 1 files changed

// File: rtl/dice_lights_engine.sv
// Dice roller and four-phase traffic-light sequencer sharing one output mux.
// Both engines run continuously; sel only chooses which registered value is shown.
module dice_lights_engine #(
    parameter int unsigned FACES         = 6,
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned RED_CYC       = 1,
    parameter int unsigned RED_AMBER_CYC = 1,
    parameter int unsigned GREEN_CYC     = 1,
    parameter int unsigned AMBER_CYC     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             roll_done
);

    localparam int unsigned MAX_RA  = (RED_CYC > RED_AMBER_CYC) ? RED_CYC : RED_AMBER_CYC;
    localparam int unsigned MAX_GA  = (GREEN_CYC > AMBER_CYC) ? GREEN_CYC : AMBER_CYC;
    localparam int unsigned MAX_CYC = (MAX_RA > MAX_GA) ? MAX_RA : MAX_GA;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    if (FACES < 2 || WIDTH < 3 || FACES >= (2 ** WIDTH) || RED_CYC < 1 ||
        RED_AMBER_CYC < 1 || GREEN_CYC < 1 || AMBER_CYC < 1) begin : g_bad_params
        $error("dice_lights_engine: illegal parameter set");
    end

    // Lamp encoding {R,A,G}
    typedef enum logic [2:0] {
        RED       = 3'b100,
        RED_AMBER = 3'b110,
        GREEN     = 3'b001,
        AMBER     = 3'b010
    } light_e;

    logic [WIDTH-1:0] dice_q, dice_d;
    light_e           light_q, light_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             btn_q, btn_d;
    logic             roll_done_q, roll_done_d;
    logic [CNT_W-1:0] term_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dice_q      <= WIDTH'(1);
            light_q     <= RED;
            dwell_q     <= '0;
            btn_q       <= 1'b0;
            roll_done_q <= 1'b0;
        end else begin
            dice_q      <= dice_d;
            light_q     <= light_d;
            dwell_q     <= dwell_d;
            btn_q       <= btn_d;
            roll_done_q <= roll_done_d;
        end
    end

    // Dice increments with wrap while held; release edge detected from btn_q.
    always_comb begin
        dice_d      = dice_q;
        btn_d       = button;
        roll_done_d = btn_q & ~button;
        if (button) begin
            dice_d = (dice_q == WIDTH'(FACES)) ? WIDTH'(1) : dice_q + WIDTH'(1);
        end
    end

    // Light sequencer: dwell counter runs to the phase's terminal count, then advances.
    always_comb begin
        light_d  = light_q;
        dwell_d  = dwell_q + CNT_W'(1);
        term_cnt = CNT_W'(RED_CYC - 1);
        case (light_q)
            RED:       term_cnt = CNT_W'(RED_CYC - 1);
            RED_AMBER: term_cnt = CNT_W'(RED_AMBER_CYC - 1);
            GREEN:     term_cnt = CNT_W'(GREEN_CYC - 1);
            AMBER:     term_cnt = CNT_W'(AMBER_CYC - 1);
            default:   term_cnt = '0;
        endcase
        if (dwell_q >= term_cnt) begin
            dwell_d = '0;
            case (light_q)
                RED:       light_d = RED_AMBER;
                RED_AMBER: light_d = GREEN;
                GREEN:     light_d = AMBER;
                AMBER:     light_d = RED;
                default:   light_d = RED;
            endcase
        end
    end

    assign out       = sel ? WIDTH'(light_q) : dice_q;
    assign roll_done = roll_done_q;

endmodule
